// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pushbutton pins and the game core.
interface button_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_press;
    logic             any_press;

    modport master (
        output btn_n,
        input  pressed, press_pulse, release_pulse, long_press, any_press
    );

    modport slave (
        input  btn_n,
        output pressed, press_pulse, release_pulse, long_press, any_press
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button 2-FF synchronizer, counter debouncer and press/release/long-press pulses.
// Define LONG_PRESS_EN to build the per-channel hold counters; otherwise long_press is 0.
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int LONG_CYCLES     = 25000000,
    parameter int LONG_W          = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 2 || (longint'(DEBOUNCE_CYCLES) >> CNT_W) != 0) begin : g_bad_debounce_cfg
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end
    if (LONG_CYCLES < 2 || (longint'(LONG_CYCLES) >> LONG_W) != 0) begin : g_bad_long_cfg
        $error("button_conditioner: LONG_CYCLES must be >= 2 and fit in LONG_W bits");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0]            sync1_q, sync2_q;
    logic [N_BTN-1:0]            stable_n_q, stable_n_d;
    logic [N_BTN-1:0]            press_q, press_d;
    logic [N_BTN-1:0]            rel_q, rel_d;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            stable_n_q <= '1;
            press_q    <= '0;
            rel_q      <= '0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= bus.btn_n;
            sync2_q    <= sync1_q;
            stable_n_q <= stable_n_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            cnt_q      <= cnt_d;
        end
    end

    // Any return of sync2 to the stable level restarts the qualification window.
    always_comb begin
        stable_n_d = stable_n_q;
        press_d    = '0;
        rel_d      = '0;
        cnt_d      = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] != stable_n_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_n_d[i] = sync2_q[i];
                    press_d[i]    = ~sync2_q[i];
                    rel_d[i]      = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign bus.pressed       = ~stable_n_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = rel_q;
    assign bus.any_press     = |press_q;

`ifdef LONG_PRESS_EN
    localparam logic [LONG_W-1:0] HOLD_FIRE = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] HOLD_SAT  = LONG_W'(LONG_CYCLES);

    logic [N_BTN-1:0][LONG_W-1:0] hold_q, hold_d;
    logic [N_BTN-1:0]             long_q, long_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            long_q <= '0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Parking one count past the fire point gives exactly one pulse per press.
    always_comb begin
        hold_d = '0;
        long_d = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (!stable_n_q[i]) begin
                hold_d[i] = (hold_q[i] == HOLD_SAT) ? HOLD_SAT : hold_q[i] + 1'b1;
                long_d[i] = (hold_q[i] == HOLD_FIRE);
            end
        end
    end

    assign bus.long_press = long_q;
`else
    assign bus.long_press = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
module tb_button_conditioner;

    localparam int N = 5;
`ifdef LONG_PRESS_EN
    localparam bit LPE = 1'b1;
`else
    localparam bit LPE = 1'b0;
`endif
    localparam logic [4:0] L_ALL = LPE ? 5'h1F : 5'h00;
    localparam logic [4:0] L_0   = LPE ? 5'h01 : 5'h00;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    button_conditioner_if #(.N_BTN(N)) bif ();

    button_conditioner #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(8),
        .CNT_W(4),
        .LONG_CYCLES(32),
        .LONG_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rst;
        logic [4:0]  btn;
        int unsigned cyc;
        logic [4:0]  pr;
        logic [4:0]  pp;
        logic [4:0]  rp;
        logic [4:0]  lp;
    } vec_t;

    vec_t        vecs[$];
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    task automatic add(input string tag, input logic rst, input logic [4:0] btn,
                       input int unsigned cyc, input logic [4:0] pr, input logic [4:0] pp,
                       input logic [4:0] rp, input logic [4:0] lp);
        vec_t v;
        v.tag = tag; v.rst = rst; v.btn = btn; v.cyc = cyc;
        v.pr = pr; v.pp = pp; v.rp = rp; v.lp = lp;
        vecs.push_back(v);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] pr, input logic [4:0] pp,
                           input logic [4:0] rp, input logic [4:0] lp);
        chk({tag, ".pressed"},       bif.pressed,        pr);
        chk({tag, ".press_pulse"},   bif.press_pulse,    pp);
        chk({tag, ".release_pulse"}, bif.release_pulse,  rp);
        chk({tag, ".long_press"},    bif.long_press,     lp);
        chk({tag, ".any_press"},     {4'b0, bif.any_press}, {4'b0, |pp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bif.btn_n = 5'h00;

        // rows: tag, reset, btn_n, edges to wait, pressed, press, release, long
        add("rst_hold",   1'b0, 5'h00,  3, 5'h00, 5'h00, 5'h00, 5'h00);
        add("rst_e9",     1'b1, 5'h00,  9, 5'h00, 5'h00, 5'h00, 5'h00);
        add("rst_e10",    1'b1, 5'h00,  1, 5'h1F, 5'h1F, 5'h00, 5'h00);
        add("rst_e11",    1'b1, 5'h00,  1, 5'h1F, 5'h00, 5'h00, 5'h00);
        add("all_long_b", 1'b1, 5'h00, 30, 5'h1F, 5'h00, 5'h00, 5'h00);
        add("all_long",   1'b1, 5'h00,  1, 5'h1F, 5'h00, 5'h00, L_ALL);
        add("all_long_a", 1'b1, 5'h00,  1, 5'h1F, 5'h00, 5'h00, 5'h00);
        add("all_rel_e9", 1'b1, 5'h1F,  9, 5'h1F, 5'h00, 5'h00, 5'h00);
        add("all_rel",    1'b1, 5'h1F,  1, 5'h00, 5'h00, 5'h1F, 5'h00);
        add("all_rel_a",  1'b1, 5'h1F,  1, 5'h00, 5'h00, 5'h00, 5'h00);
        add("b0_e9",      1'b1, 5'h1E,  9, 5'h00, 5'h00, 5'h00, 5'h00);
        add("b0_press",   1'b1, 5'h1E,  1, 5'h01, 5'h01, 5'h00, 5'h00);
        add("b0_press_a", 1'b1, 5'h1E,  1, 5'h01, 5'h00, 5'h00, 5'h00);
        add("b0_long_b",  1'b1, 5'h1E, 30, 5'h01, 5'h00, 5'h00, 5'h00);
        add("b0_long",    1'b1, 5'h1E,  1, 5'h01, 5'h00, 5'h00, L_0);
        add("b0_long_a",  1'b1, 5'h1E, 20, 5'h01, 5'h00, 5'h00, 5'h00);
        add("b0_rel_e9",  1'b1, 5'h1F,  9, 5'h01, 5'h00, 5'h00, 5'h00);
        add("b0_rel",     1'b1, 5'h1F,  1, 5'h00, 5'h00, 5'h01, 5'h00);
        add("b0_rel_a",   1'b1, 5'h1F,  1, 5'h00, 5'h00, 5'h00, 5'h00);
        add("b24_e9",     1'b1, 5'h0B,  9, 5'h00, 5'h00, 5'h00, 5'h00);
        add("b24_press",  1'b1, 5'h0B,  1, 5'h14, 5'h14, 5'h00, 5'h00);
        add("b24_press_a",1'b1, 5'h0B,  1, 5'h14, 5'h00, 5'h00, 5'h00);
        add("b24_rel",    1'b1, 5'h1F, 10, 5'h00, 5'h00, 5'h14, 5'h00);
        add("b3_cnt5",    1'b1, 5'h17,  7, 5'h00, 5'h00, 5'h00, 5'h00);
        add("b3_rst_now", 1'b0, 5'h17,  0, 5'h00, 5'h00, 5'h00, 5'h00);
        add("b3_rst_hold",1'b0, 5'h17,  2, 5'h00, 5'h00, 5'h00, 5'h00);
        add("b3_e9",      1'b1, 5'h17,  9, 5'h00, 5'h00, 5'h00, 5'h00);
        add("b3_press",   1'b1, 5'h17,  1, 5'h08, 5'h08, 5'h00, 5'h00);
        add("b3_press_a", 1'b1, 5'h17,  1, 5'h08, 5'h00, 5'h00, 5'h00);
        add("b3_rel",     1'b1, 5'h1F, 10, 5'h00, 5'h00, 5'h08, 5'h00);
        add("idle",       1'b1, 5'h1F,  3, 5'h00, 5'h00, 5'h00, 5'h00);

        foreach (vecs[k]) begin
            reset     = vecs[k].rst;
            bif.btn_n = vecs[k].btn;
            step(vecs[k].cyc);
            chk_all(vecs[k].tag, vecs[k].pr, vecs[k].pp, vecs[k].rp, vecs[k].lp);
        end

        // Bounce on btn_n[1]: 3-cycle phases never reach the 8-cycle window.
        for (int p = 0; p < 10; p++) begin
            bif.btn_n = (p % 2 == 0) ? 5'h1D : 5'h1F;
            for (int c = 0; c < 3; c++) begin
                step(1);
                chk("bounce.press_pulse", bif.press_pulse, 5'h00);
                chk("bounce.pressed",     bif.pressed,     5'h00);
            end
        end
        bif.btn_n = 5'h1D;
        step(9);
        chk("settle_e9.press_pulse", bif.press_pulse, 5'h00);
        step(1);
        chk("settle.press_pulse", bif.press_pulse, 5'h02);
        chk("settle.pressed",     bif.pressed,     5'h02);
        step(1);
        chk("settle_a.press_pulse", bif.press_pulse, 5'h00);
        bif.btn_n = 5'h1F;
        step(10);
        chk("b1_rel.release_pulse", bif.release_pulse, 5'h02);
        chk("b1_rel.pressed",       bif.pressed,       5'h00);
        step(1);
        chk("b1_rel_a.release_pulse", bif.release_pulse, 5'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
